// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined); byte out ~2+HALF+9*CLKS_PER_BIT+1 clocks after the start edge.
// No back-pressure: rx_done/frame_err/parity_err are single-cycle strobes and uart_rx_data holds until the next good byte.
module uart_byte_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_byte_rx: CLK_FREQ/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             rx_meta, rx_s;
  logic             done_nxt, ferr_nxt, perr_nxt;
`ifdef UART_RX_PARITY_EN
  logic             par_bad, par_bad_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    done_nxt    = 1'b0;
    ferr_nxt    = 1'b0;
    perr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == CNT_MID) begin
          cnt_nxt     = '0;
          bit_idx_nxt = 3'd0;
          state_nxt   = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt            = '0;
          shreg_nxt[bit_idx] = rx_s;
          bit_idx_nxt        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt     = '0;
          par_bad_nxt = (rx_s != ^shreg);
          state_nxt   = STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          // A low stop bit wins over any parity verdict.
          if (!rx_s) begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end else begin
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) perr_nxt = 1'b1;
            else         done_nxt = 1'b1;
`else
            done_nxt = 1'b1;
`endif
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= 3'd0;
      shreg        <= 8'h00;
      uart_rx_data <= 8'h00;
      rx_done      <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
`endif
    end else begin
      rx_meta    <= uart_rxd;
      rx_s       <= rx_meta;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shreg      <= shreg_nxt;
      rx_done    <= done_nxt;
      frame_err  <= ferr_nxt;
      parity_err <= perr_nxt;
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_bad_nxt;
`endif
      if (done_nxt) uart_rx_data <= shreg;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule
